// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, opcode/funct encodings and field positions.
// Also provides the one-hot to index helper used by the priority encoder.
package cp0_pkg;

    typedef enum logic [4:0] {
        REG_EPC     = 5'd0,
        REG_STATUS  = 5'd1,
        REG_MASK    = 5'd2,
        REG_CAUSE   = 5'd3,
        REG_PENDING = 5'd4
    } cp0_reg_e;

    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] FUNCT_ERET = 6'b011000;

    localparam int STATUS_IE      = 0;
    localparam int STATUS_EXL     = 1;
    localparam int CAUSE_IDX_LSB  = 2;
    localparam int CAUSE_PEND_LSB = 8;

    function automatic logic [2:0] oh_index(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cp0_prio_enc.sv
// Fixed-priority encoder: lowest-numbered asserted request wins.
module cp0_prio_enc
    import cp0_pkg::*;
#(
    parameter int NSRC = 3
) (
    input  logic [NSRC-1:0] i_req,
    output logic [2:0]      o_idx,
    output logic            o_valid,
    output logic [NSRC-1:0] o_onehot
);

    // Two's-complement trick isolates the lowest set bit.
    assign o_onehot = i_req & (~i_req + NSRC'(1));
    assign o_idx    = oh_index(8'(o_onehot));
    assign o_valid  = |i_req;

endmodule

// File: rtl/cp0_vec.sv
// CP0 exception vectoring: EPC/STATUS/MASK/CAUSE/PENDING registers, MFC0/MTC0 access,
// fixed-priority exception acceptance and ERET return.
module cp0_vec
    import cp0_pkg::*;
#(
    parameter int          NSRC       = 3,
    parameter logic [31:0] EXC_VECTOR = 32'h00000180
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     inst,
    input  logic [31:0]     pc_in,
    input  logic [31:0]     d_in,
    input  logic            enable,
    input  logic [NSRC-1:0] exp_req,
    output logic            exregwrite,
    output logic            iseret,
    output logic            hasexp,
    output logic            expblock,
    output logic [31:0]     pc_out,
    output logic [31:0]     d_out
);

    logic [31:0]     r_epc;
    logic            r_ie;
    logic            r_exl;
    logic [NSRC-1:0] r_mask;
    logic [2:0]      r_cause_idx;
    logic [NSRC-1:0] r_pending;

    cp0_reg_e        w_sel;
    logic            w_cop0;
    logic [NSRC-1:0] w_active;
    logic [NSRC-1:0] w_win_oh;
    logic [NSRC-1:0] w_taken;
    logic [2:0]      w_win_idx;
    logic            w_win_valid;
    logic            w_wr_epc;
    logic            w_wr_status;
    logic            w_wr_mask;
    logic            w_wr_cause;
    logic [31:0]     w_status;
    logic [31:0]     w_cause;
    logic            w_unused_inst;

    assign w_sel         = cp0_reg_e'(inst[15:11]);
    assign w_cop0        = (inst[31:26] == OP_COP0);
    assign exregwrite    = w_cop0 & ~inst[25] & ~inst[23];
    assign iseret        = w_cop0 & inst[25] & (inst[5:0] == FUNCT_ERET);
    assign w_unused_inst = ^{inst[24], inst[22:16], inst[10:6]};

    assign w_active = r_pending & r_mask;

    cp0_prio_enc #(.NSRC(NSRC)) u_prio (
        .i_req    (w_active),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid),
        .o_onehot (w_win_oh)
    );

    assign hasexp   = r_ie & ~r_exl & w_win_valid;
    assign expblock = r_exl | ~r_ie;
    assign w_taken  = hasexp ? w_win_oh : '0;

    // An accepted exception owns EPC, CAUSE and EXL this cycle; the IE write still lands.
    assign w_wr_epc    = enable & (w_sel == REG_EPC) & ~hasexp;
    assign w_wr_status = enable & (w_sel == REG_STATUS);
    assign w_wr_mask   = enable & (w_sel == REG_MASK);
    assign w_wr_cause  = enable & (w_sel == REG_CAUSE) & ~hasexp;

    always_comb begin
        w_status             = 32'd0;
        w_status[STATUS_IE]  = r_ie;
        w_status[STATUS_EXL] = r_exl;
        w_cause                           = 32'd0;
        w_cause[CAUSE_IDX_LSB +: 3]       = r_cause_idx;
        w_cause[CAUSE_PEND_LSB +: NSRC]   = r_pending;
    end

    always_comb begin
        case (w_sel)
            REG_EPC:     d_out = r_epc;
            REG_STATUS:  d_out = w_status;
            REG_MASK:    d_out = 32'(r_mask);
            REG_CAUSE:   d_out = w_cause;
            REG_PENDING: d_out = 32'(r_pending);
            default:     d_out = 32'd0;
        endcase
    end

    always_comb begin
        if (hasexp) begin
            pc_out = EXC_VECTOR;
        end else if (iseret) begin
            pc_out = r_epc;
        end else begin
            pc_out = pc_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_epc <= 32'd0;
        end else if (hasexp) begin
            r_epc <= pc_in;
        end else if (w_wr_epc) begin
            r_epc <= d_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ie <= 1'b1;
        end else if (w_wr_status) begin
            r_ie <= d_in[STATUS_IE];
        end
    end

    // ERET clearing EXL takes precedence over a concurrent MTC0 to STATUS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exl <= 1'b0;
        end else if (hasexp) begin
            r_exl <= 1'b1;
        end else if (iseret) begin
            r_exl <= 1'b0;
        end else if (w_wr_status) begin
            r_exl <= d_in[STATUS_EXL];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '1;
        end else if (w_wr_mask) begin
            r_mask <= d_in[NSRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cause_idx <= 3'd0;
        end else if (hasexp) begin
            r_cause_idx <= w_win_idx;
        end else if (w_wr_cause) begin
            r_cause_idx <= d_in[CAUSE_IDX_LSB +: 3];
        end
    end

    // A request still asserted on the acceptance edge re-pends immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_taken) | exp_req;
        end
    end

endmodule
